sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
Shares the single external 1Mx16 SRAM port between two requesters: the CPU memory path (port 0, fed from MAR/MDR, driven by the state controller) and an auxiliary master (port 1, e.g. a program loader or debug reader).
Arbitrates round-robin, sequences each access with active-low CE/OE/WE/UB/LB strobes and a programmable access-cycle count, and returns read data with a one-cycle done pulse.
Sits between the requesters and the tristate SRAM buffer, in place of direct strobe generation.

Parameters:
ACCESS_CYCLES, 2, cycles the strobe (OE or WE) is held active per access; legal range 1..15
AW, 20, SRAM address width

Ports:
Clk  in  1  system clock, all state changes on rising edge
Reset  in  1  asynchronous, active-low reset
req0  in  1  port 0 (CPU) request
we0  in  1  port 0 write (1) / read (0)
addr0  in  AW  port 0 address
wdata0  in  16  port 0 write data
done0  out  1  port 0 access complete, one-cycle pulse
req1  in  1  port 1 (aux) request
we1  in  1  port 1 write / read
addr1  in  AW  port 1 address
wdata1  in  16  port 1 write data
done1  out  1  port 1 access complete, one-cycle pulse
rdata  out  16  read data of the last completed read, shared by both ports
busy  out  1  high in any state other than IDLE
owner  out  1  port currently or last granted
CE, OE, WE, UB, LB  out  1 each  SRAM strobes, active-low
ADDR  out  AW  SRAM address
Data_to_SRAM  out  16  write data toward the tristate buffer
drive_en  out  1  tristate output enable, high only while a write is driving
Data_from_SRAM  in  16  read data from the tristate buffer

Behaviour:
- Reset (async, Reset=0): state=IDLE; CE=OE=WE=UB=LB=1; ADDR=0; Data_to_SRAM=0; drive_en=0; rdata=0; done0=done1=0; busy=0; owner=0; last-served pointer=1, so port 0 wins the first tie. All outputs are registered.
- States:
  - IDLE: sample req0/req1. Neither set -> stay. One set -> grant it. Both set -> grant the port not equal to the last-served pointer. On grant: latch addr, we, wdata of the winner; set owner and pointer; load counter=ACCESS_CYCLES-1; go ACCESS.
  - ACCESS: CE=UB=LB=0; ADDR=latched address. Read: OE=0, WE=1, drive_en=0. Write: WE=0, OE=1, drive_en=1, Data_to_SRAM=latched wdata. Counter decrements each cycle; when counter=0: a read captures Data_from_SRAM into rdata on that edge; go DONE.
  - DONE: all strobes=1; drive_en stays 1 for writes (data hold) and drops on exit. Pulse the owner's done for exactly this cycle. Go IDLE.
- Latency: a request sampled in IDLE cycle N gives ACCESS in cycles N+1..N+ACCESS_CYCLES and done in cycle N+ACCESS_CYCLES+1, with rdata valid from that cycle until the next read completes.
- Handshake:
  - A requester holds req, we, addr and wdata stable until it sees its done. It must deassert req on the edge where done=1; a req still high in the following IDLE cycle is a new access.
  - Requests are sampled only in IDLE. Dropping req during ACCESS/DONE does not abort the access; done still pulses.
- Back-to-back: with both ports requesting continuously, grants alternate 0,1,0,1. Each access occupies ACCESS_CYCLES+2 cycles (IDLE+ACCESS+DONE).
- Reset mid-access: strobes return to 1 and drive_en to 0 immediately (async), no done is produced, and rdata clears to 0.
- WE and OE are never low in the same cycle. drive_en=1 never coincides with OE=0.

Test Plan:
- Reset: Reset=0 mid-write with WE=0 -> WE, CE, OE go 1 and drive_en 0 within the same cycle; done0=done1=0; busy=0.
- Single read: ACCESS_CYCLES=2; port 0 reads addr 0x00012; SRAM model returns 0xBEEF -> CE=OE=0 for exactly 2 cycles; done0 at cycle N+3; rdata=0xBEEF; done1 stays 0.
- Single write: port 1 writes 0x1234 to 0x00400 -> WE=0 for 2 cycles with ADDR=0x00400 and Data_to_SRAM=0x1234; drive_en high for 3 cycles; OE stays 1; done1 pulses once; a port 0 readback returns 0x1234.
- Contention: req0 and req1 both rise in the same IDLE cycle after reset, both held through repeated accesses -> grant order 0,1,0,1; owner toggles; each done pulses once per access.
- Early drop: port 0 lowers req0 during ACCESS -> access completes and done0 still pulses; no second access starts.
- Param sweep: ACCESS_CYCLES=1 and 15 -> strobe width 1 and 15 cycles; done at N+2 and N+16 respectively.

Source files
------------

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//
// Shares one external 1Mx16 asynchronous SRAM between two masters:
//   port 0 : CPU memory path (MAR/MDR side, driven by the state controller)
//   port 1 : auxiliary master (program loader, debug reader, ...)
//
// Each access is a three-phase sequence:
//   IDLE   : requests are sampled and a winner is granted
//   ACCESS : CE/UB/LB low, plus OE (read) or WE (write) low, held for
//            ACCESS_CYCLES cycles
//   DONE   : strobes released, the owner's done pulses for one cycle
// When both ports ask at once, the port that was not served last wins.
// Every output is a flop, so the SRAM strobes are glitch-free.
//
// Parameters:
//   ACCESS_CYCLES  strobe width in cycles (1..15)
//   AW             SRAM address width
//
// Ports:
//   Clk, Reset          clock (rising edge), asynchronous active-low reset
//   req0/we0/addr0/wdata0, done0   port 0 request, direction, address,
//                                  write data and completion pulse
//   req1/we1/addr1/wdata1, done1   port 1, same meaning
//   rdata               data of the last completed read (shared)
//   busy                high whenever the sequencer is not in IDLE
//   owner               port currently or most recently granted
//   CE, OE, WE, UB, LB  active-low SRAM strobes
//   ADDR                SRAM address
//   Data_to_SRAM        write data toward the tristate buffer
//   drive_en            tristate enable, high only while a write drives
//   Data_from_SRAM      read data from the tristate buffer
// ---------------------------------------------------------------------------
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int AW            = 20
) (
  input  logic          Clk,
  input  logic          Reset,

  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [15:0]   wdata0,
  output logic          done0,

  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [15:0]   wdata1,
  output logic          done1,

  output logic [15:0]   rdata,
  output logic          busy,
  output logic          owner,

  output logic          CE,
  output logic          OE,
  output logic          WE,
  output logic          UB,
  output logic          LB,
  output logic [AW-1:0] ADDR,
  output logic [15:0]   Data_to_SRAM,
  output logic          drive_en,
  input  logic [15:0]   Data_from_SRAM
);

  // The counter is loaded with ACCESS_CYCLES-1 and the access ends on the
  // cycle it reads zero, which gives exactly ACCESS_CYCLES strobe cycles.
  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_t;

  state_t        r_state;
  logic          r_ptr;
  logic          r_we;
  logic [3:0]    r_cnt;

  logic          w_anyReq;
  logic          w_grant1;
  logic          w_winWe;
  logic [AW-1:0] w_winAddr;
  logic [15:0]   w_winWdata;

  // Winner selection. Port 1 wins when it is the only requester, or when
  // both request and port 0 was served last (pointer == 0).
  always_comb begin
    w_anyReq   = req0 | req1;
    w_grant1   = req1 & (~req0 | ~r_ptr);
    w_winWe    = w_grant1 ? we1    : we0;
    w_winAddr  = w_grant1 ? addr1  : addr0;
    w_winWdata = w_grant1 ? wdata1 : wdata0;
  end

  // Sequencer with registered outputs. The strobes for ACCESS are set on
  // the grant edge so they are already valid in the first ACCESS cycle, and
  // released on the final counter edge so DONE starts with them high.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state      <= ST_IDLE;
      r_ptr        <= 1'b1;
      r_we         <= 1'b0;
      r_cnt        <= 4'd0;
      CE           <= 1'b1;
      OE           <= 1'b1;
      WE           <= 1'b1;
      UB           <= 1'b1;
      LB           <= 1'b1;
      ADDR         <= '0;
      Data_to_SRAM <= 16'h0000;
      drive_en     <= 1'b0;
      rdata        <= 16'h0000;
      done0        <= 1'b0;
      done1        <= 1'b0;
      busy         <= 1'b0;
      owner        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          if (w_anyReq) begin
            r_state <= ST_ACCESS;
            r_ptr   <= w_grant1;
            owner   <= w_grant1;
            r_we    <= w_winWe;
            r_cnt   <= CNT_LOAD;
            busy    <= 1'b1;
            CE      <= 1'b0;
            UB      <= 1'b0;
            LB      <= 1'b0;
            ADDR    <= w_winAddr;
            if (w_winWe) begin
              WE           <= 1'b0;
              OE           <= 1'b1;
              drive_en     <= 1'b1;
              Data_to_SRAM <= w_winWdata;
            end else begin
              WE       <= 1'b1;
              OE       <= 1'b0;
              drive_en <= 1'b0;
            end
          end
        end

        ST_ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_DONE;
            CE      <= 1'b1;
            OE      <= 1'b1;
            WE      <= 1'b1;
            UB      <= 1'b1;
            LB      <= 1'b1;
            if (!r_we) begin
              rdata <= Data_from_SRAM;
            end
            done0 <= ~owner;
            done1 <= owner;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        // drive_en is deliberately left high through DONE on writes so the
        // data bus is held past the WE rising edge.
        ST_DONE: begin
          r_state  <= ST_IDLE;
          done0    <= 1'b0;
          done1    <= 1'b0;
          drive_en <= 1'b0;
          busy     <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter
//
// Directed bench for sram_arbiter. The main instance uses ACCESS_CYCLES=2
// and talks to a small behavioural SRAM; two extra instances with
// ACCESS_CYCLES=1 and 15 check the strobe width and done latency at the
// ends of the legal range. Inputs are driven and outputs sampled on the
// falling clock edge.
// ---------------------------------------------------------------------------
module tb_sram_arbiter;

  logic        Clk;
  logic        Reset;

  logic        req0, we0, req1, we1;
  logic [19:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        done0, done1;
  logic [15:0] rdata;
  logic        busy, owner;
  logic        CE, OE, WE, UB, LB;
  logic [19:0] ADDR;
  logic [15:0] Data_to_SRAM;
  logic        drive_en;
  logic [15:0] Data_from_SRAM;

  logic [1:0]  swReq, swDone0, swDone1, swBusy, swOwner;
  logic [1:0]  swCE, swOE, swWE, swUB, swLB, swDrive;
  logic [15:0] swRdata [2];
  logic [19:0] swAddr [2];
  logic [15:0] swDout [2];

  logic [15:0] mem [0:4095];

  int vectors;
  int miscompares;

  sram_arbiter #(.ACCESS_CYCLES(2), .AW(20)) dut (
    .Clk(Clk), .Reset(Reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .done0(done0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .done1(done1),
    .rdata(rdata), .busy(busy), .owner(owner),
    .CE(CE), .OE(OE), .WE(WE), .UB(UB), .LB(LB),
    .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM), .drive_en(drive_en),
    .Data_from_SRAM(Data_from_SRAM)
  );

  sram_arbiter #(.ACCESS_CYCLES(1), .AW(20)) dutShort (
    .Clk(Clk), .Reset(Reset),
    .req0(swReq[0]), .we0(1'b0), .addr0(20'h00012), .wdata0(16'h0000), .done0(swDone0[0]),
    .req1(1'b0), .we1(1'b0), .addr1(20'h00000), .wdata1(16'h0000), .done1(swDone1[0]),
    .rdata(swRdata[0]), .busy(swBusy[0]), .owner(swOwner[0]),
    .CE(swCE[0]), .OE(swOE[0]), .WE(swWE[0]), .UB(swUB[0]), .LB(swLB[0]),
    .ADDR(swAddr[0]), .Data_to_SRAM(swDout[0]), .drive_en(swDrive[0]),
    .Data_from_SRAM(16'hA5A5)
  );

  sram_arbiter #(.ACCESS_CYCLES(15), .AW(20)) dutLong (
    .Clk(Clk), .Reset(Reset),
    .req0(swReq[1]), .we0(1'b0), .addr0(20'h00012), .wdata0(16'h0000), .done0(swDone0[1]),
    .req1(1'b0), .we1(1'b0), .addr1(20'h00000), .wdata1(16'h0000), .done1(swDone1[1]),
    .rdata(swRdata[1]), .busy(swBusy[1]), .owner(swOwner[1]),
    .CE(swCE[1]), .OE(swOE[1]), .WE(swWE[1]), .UB(swUB[1]), .LB(swLB[1]),
    .ADDR(swAddr[1]), .Data_to_SRAM(swDout[1]), .drive_en(swDrive[1]),
    .Data_from_SRAM(16'h5A5A)
  );

  // 100 MHz clock.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Behavioural SRAM: asynchronous read of the low address bits, write
  // committed on every clock edge while CE and WE are both low.
  assign Data_from_SRAM = mem[ADDR[11:0]];

  always @(posedge Clk) begin
    if (!CE && !WE) mem[ADDR[11:0]] <= Data_to_SRAM;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Runs one access on the main instance and reports what it saw, cycle by
  // cycle, until the requesting port's done (or a 40-cycle timeout).
  task automatic applyStimulus(input logic port, input logic isWrite,
                               input logic [19:0] addr, input logic [15:0] wdata,
                               input int dropAt,
                               output int doneAt, output int strobeCycles,
                               output int driveCycles, output int otherDone,
                               output int badCycles, output int doneRepeat);
    logic mine, other;
    doneAt = 0; strobeCycles = 0; driveCycles = 0;
    otherDone = 0; badCycles = 0; doneRepeat = 0;
    @(negedge Clk);
    if (port) begin
      req1 = 1'b1; we1 = isWrite; addr1 = addr; wdata1 = wdata;
    end else begin
      req0 = 1'b1; we0 = isWrite; addr0 = addr; wdata0 = wdata;
    end
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clk);
      mine  = port ? done1 : done0;
      other = port ? done0 : done1;
      if (!CE && (isWrite ? !WE : !OE)) strobeCycles++;
      if (drive_en) driveCycles++;
      if (other) otherDone++;
      if (!OE && !WE) badCycles++;
      if (!OE && drive_en) badCycles++;
      if (isWrite && !OE) badCycles++;
      if (!CE && ADDR != addr) badCycles++;
      if (isWrite && !WE && Data_to_SRAM != wdata) badCycles++;
      if (k == dropAt || mine) begin
        if (port) req1 = 1'b0; else req0 = 1'b0;
      end
      if (mine) begin
        doneAt = k;
        break;
      end
    end
    @(negedge Clk);
    doneRepeat = port ? int'(done1) : int'(done0);
  endtask

  initial begin
    int doneAt, strobeCycles, driveCycles, otherDone, badCycles, doneRepeat;
    int evPort [$];
    int evTime [$];
    int busyCycles;
    int swDoneAt [2];
    int swWidth [2];

    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    mem[12'h012] = 16'hBEEF;

    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    swReq = 2'b00;
    Reset = 1'b1;
    #1 Reset = 1'b0;
    #2;
    checkOutput("reset CE", int'(CE), 1);
    checkOutput("reset OE/WE/UB/LB", int'({OE, WE, UB, LB}), 4'hF);
    checkOutput("reset ADDR", int'(ADDR), 0);
    checkOutput("reset drive_en", int'(drive_en), 0);
    checkOutput("reset done", int'({done0, done1}), 0);
    checkOutput("reset busy/owner", int'({busy, owner}), 0);
    checkOutput("reset rdata", int'(rdata), 0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;

    // Single read on port 0.
    applyStimulus(1'b0, 1'b0, 20'h00012, 16'h0000, 0,
                  doneAt, strobeCycles, driveCycles, otherDone, badCycles, doneRepeat);
    checkOutput("read done cycle", doneAt, 3);
    checkOutput("read OE width", strobeCycles, 2);
    checkOutput("read rdata", int'(rdata), 16'hBEEF);
    checkOutput("read done1 quiet", otherDone, 0);
    checkOutput("read strobe rules", badCycles, 0);
    checkOutput("read done single", doneRepeat, 0);
    checkOutput("read back to idle", int'(busy), 0);

    // Single write on port 1, then read it back on port 0.
    applyStimulus(1'b1, 1'b1, 20'h00400, 16'h1234, 0,
                  doneAt, strobeCycles, driveCycles, otherDone, badCycles, doneRepeat);
    checkOutput("write done cycle", doneAt, 3);
    checkOutput("write WE width", strobeCycles, 2);
    checkOutput("write drive_en cycles", driveCycles, 3);
    checkOutput("write strobe rules", badCycles, 0);
    checkOutput("write done single", doneRepeat, 0);
    checkOutput("write owner", int'(owner), 1);
    checkOutput("write rdata kept", int'(rdata), 16'hBEEF);
    applyStimulus(1'b0, 1'b0, 20'h00400, 16'h0000, 0,
                  doneAt, strobeCycles, driveCycles, otherDone, badCycles, doneRepeat);
    checkOutput("readback done cycle", doneAt, 3);
    checkOutput("readback rdata", int'(rdata), 16'h1234);

    // Contention right after reset: both ports hold req; expected grant
    // order 0,1,0,1 with one access every 4 cycles.
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 20'h00012;
    req1 = 1'b1; we1 = 1'b0; addr1 = 20'h00400;
    for (int k = 1; k <= 16; k++) begin
      @(negedge Clk);
      if (done0) begin evPort.push_back(0); evTime.push_back(k); end
      if (done1) begin evPort.push_back(1); evTime.push_back(k); end
      if (done0 || done1) checkOutput("contention owner", int'(owner), int'(done1));
    end
    req0 = 1'b0;
    req1 = 1'b0;
    checkOutput("contention done count", evPort.size(), 4);
    for (int i = 0; i < evPort.size() && i < 4; i++) begin
      checkOutput($sformatf("contention grant %0d port", i), evPort[i], i % 2);
      checkOutput($sformatf("contention grant %0d cycle", i), evTime[i], 3 + 4 * i);
    end
    busyCycles = 0;
    for (int k = 0; k < 10 && busy; k++) begin
      @(negedge Clk);
      busyCycles++;
    end
    checkOutput("contention drains", int'(busy), 0);

    // Early drop: req0 falls in the first ACCESS cycle.
    applyStimulus(1'b0, 1'b0, 20'h00012, 16'h0000, 1,
                  doneAt, strobeCycles, driveCycles, otherDone, badCycles, doneRepeat);
    checkOutput("early drop done cycle", doneAt, 3);
    checkOutput("early drop rdata", int'(rdata), 16'hBEEF);
    busyCycles = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      if (busy) busyCycles++;
    end
    checkOutput("early drop no restart", busyCycles, 0);

    // Reset in the middle of a write.
    @(negedge Clk);
    req1 = 1'b1; we1 = 1'b1; addr1 = 20'h00007; wdata1 = 16'h5555;
    @(negedge Clk);
    checkOutput("midreset WE low before", int'(WE), 0);
    checkOutput("midreset drive before", int'(drive_en), 1);
    #2 Reset = 1'b0;
    #1;
    checkOutput("midreset CE/OE/WE", int'({CE, OE, WE}), 3'b111);
    checkOutput("midreset drive_en", int'(drive_en), 0);
    checkOutput("midreset done", int'({done0, done1}), 0);
    checkOutput("midreset busy", int'(busy), 0);
    checkOutput("midreset rdata", int'(rdata), 0);
    @(negedge Clk);
    req1 = 1'b0; we1 = 1'b0;
    Reset = 1'b1;

    // Parameter sweep: ACCESS_CYCLES = 1 and 15 side by side.
    @(negedge Clk);
    swReq = 2'b11;
    swDoneAt = '{0, 0};
    swWidth = '{0, 0};
    for (int k = 1; k <= 24; k++) begin
      @(negedge Clk);
      for (int i = 0; i < 2; i++) begin
        if (!swCE[i] && !swOE[i]) swWidth[i]++;
        if (swDone0[i] && swDoneAt[i] == 0) begin
          swDoneAt[i] = k;
          swReq[i] = 1'b0;
        end
      end
    end
    checkOutput("sweep AC1 done cycle", swDoneAt[0], 2);
    checkOutput("sweep AC1 width", swWidth[0], 1);
    checkOutput("sweep AC1 rdata", int'(swRdata[0]), 16'hA5A5);
    checkOutput("sweep AC15 done cycle", swDoneAt[1], 16);
    checkOutput("sweep AC15 width", swWidth[1], 15);
    checkOutput("sweep AC15 rdata", int'(swRdata[1]), 16'h5A5A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
